// File: rtl/llc_cmd_frontend.sv
// llc_cmd_frontend: request front end that filters trace commands, buffers them in a FIFO and splits addresses for the LLC
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid/in_ready/in_command/in_address   request handshake from the trace source
//   op_valid/op_ready/op_command/op_tag/op_index/op_offset   registered FIFO head to the cache
//   fill_level                        FIFO occupancy
//   rd_cnt/wr_cnt/snp_cnt/err_cnt     saturating per-class request counters
module llc_cmd_frontend #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [4:0]                           in_command,
    input  logic [ADDR_W-1:0]                    in_address,
    output logic                                 op_valid,
    input  logic                                 op_ready,
    output logic [3:0]                           op_command,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]   op_tag,
    output logic [INDEX_W-1:0]                   op_index,
    output logic [OFFSET_W-1:0]                  op_offset,
    output logic [$clog2(DEPTH):0]               fill_level,
    output logic [CNT_W-1:0]                     rd_cnt,
    output logic [CNT_W-1:0]                     wr_cnt,
    output logic [CNT_W-1:0]                     snp_cnt,
    output logic [CNT_W-1:0]                     err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 + ADDR_W;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW:0]       r_wp, r_rp, w_wp_n, w_rp_n, w_cnt_n;
    logic [3:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_op_valid, r_in_ready;
    logic [CNT_W-1:0]  r_rd, r_wr, r_snp, r_err;
    logic              w_legal, w_acc, w_push, w_pop;
    logic              w_rd, w_wr, w_snp, w_err;
    logic [EW-1:0]     w_in_ent, w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        w_legal  = in_command <= 5'd6 || in_command == 5'd8 || in_command == 5'd9;
        w_acc    = in_valid && r_in_ready;
        w_push   = w_acc && w_legal;
        w_pop    = r_op_valid && op_ready;
        w_rd     = w_acc && (in_command == 5'd0 || in_command == 5'd2);
        w_wr     = w_acc && in_command == 5'd1;
        w_snp    = w_acc && in_command >= 5'd3 && in_command <= 5'd6;
        w_err    = w_acc && !w_legal;
        w_wp_n   = r_wp + {{AW{1'b0}}, w_push};
        w_rp_n   = r_rp + {{AW{1'b0}}, w_pop};
        w_cnt_n  = w_wp_n - w_rp_n;
        w_in_ent = {in_command[3:0], in_address};
        // next head is the slot being written this cycle: bypass the array
        w_head   = (w_push && w_rp_n == r_wp) ? w_in_ent : r_mem[w_rp_n[AW-1:0]];
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp[AW-1:0]] <= w_in_ent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_op_valid <= 1'b0;
            r_in_ready <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_snp      <= '0;
            r_err      <= '0;
        end else begin
            r_wp       <= w_wp_n;
            r_rp       <= w_rp_n;
            r_op_valid <= w_cnt_n != '0;
            r_in_ready <= w_cnt_n != (AW+1)'(DEPTH);
            if (w_cnt_n != '0) {r_cmd, r_addr} <= w_head;
            r_rd       <= sat_inc(r_rd, w_rd);
            r_wr       <= sat_inc(r_wr, w_wr);
            r_snp      <= sat_inc(r_snp, w_snp);
            r_err      <= sat_inc(r_err, w_err);
        end
    end

    assign in_ready   = r_in_ready;
    assign op_valid   = r_op_valid;
    assign op_command = r_cmd;
    assign op_tag     = r_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign op_index   = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign op_offset  = r_addr[OFFSET_W-1:0];
    assign fill_level = r_wp - r_rp;
    assign rd_cnt     = r_rd;
    assign wr_cnt     = r_wr;
    assign snp_cnt    = r_snp;
    assign err_cnt    = r_err;
endmodule

// File: tb/tb_llc_cmd_frontend.sv
// tb_llc_cmd_frontend: scoreboard bench for llc_cmd_frontend with a queue-based reference model
module tb_llc_cmd_frontend;
    localparam int ADDR_W = 32, OFFSET_W = 6, INDEX_W = 14, DEPTH = 8, CNT_W = 16;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam longint MAXC = (64'd1 << CNT_W) - 1;

    logic clk = 0, rst = 1, in_valid = 0, in_ready, op_valid, op_ready = 0;
    logic [4:0] in_command = 0;
    logic [ADDR_W-1:0] in_address = 0;
    logic [3:0] op_command;
    logic [TAG_W-1:0] op_tag;
    logic [INDEX_W-1:0] op_index;
    logic [OFFSET_W-1:0] op_offset;
    logic [$clog2(DEPTH):0] fill_level;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, snp_cnt, err_cnt;

    llc_cmd_frontend #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
        .in_address(in_address), .op_valid(op_valid), .op_ready(op_ready), .op_command(op_command),
        .op_tag(op_tag), .op_index(op_index), .op_offset(op_offset), .fill_level(fill_level),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .snp_cnt(snp_cnt), .err_cnt(err_cnt));

    always #5 clk = ~clk;

    typedef struct {longint cmd; longint addr;} req_t;
    req_t exp_q[$];
    req_t last = '{0, 0};
    int checks = 0, errors = 0;
    int e_fill = 0;
    longint e_rd = 0, e_wr = 0, e_snp = 0, e_err = 0;

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint c);
        return c == MAXC ? c : c + 1;
    endfunction

    // reference model: occupancy, ready and counters follow from the accept/pop rules
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            e_fill = 0; e_rd = 0; e_wr = 0; e_snp = 0; e_err = 0;
        end else begin
            automatic int c = int'(in_command);
            automatic bit acc = in_valid && e_fill < DEPTH;
            automatic bit legal = c <= 6 || c == 8 || c == 9;
            automatic bit pop = e_fill > 0 && op_ready;
            chk("fill_level", fill_level, e_fill);
            chk("in_ready", in_ready, e_fill < DEPTH);
            chk("op_valid", op_valid, e_fill > 0);
            chk("rd_cnt", rd_cnt, e_rd);
            chk("wr_cnt", wr_cnt, e_wr);
            chk("snp_cnt", snp_cnt, e_snp);
            chk("err_cnt", err_cnt, e_err);
            if (acc) begin
                if (legal) exp_q.push_back('{c, longint'(in_address)});
                else e_err = sat(e_err);
                if (c == 0 || c == 2) e_rd = sat(e_rd);
                if (c == 1) e_wr = sat(e_wr);
                if (c >= 3 && c <= 6) e_snp = sat(e_snp);
            end
            e_fill += int'(acc && legal) - int'(pop);
        end
    end

    // monitor: compares the presented head against the scoreboard front
    always @(negedge clk) begin
        if (rst) last = '{0, 0};
        else if (op_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL op_unexpected actual=valid expected=empty t=%0t", $time);
            end else begin
                automatic req_t e = exp_q[0];
                chk("op_command", op_command, e.cmd);
                chk("op_tag", op_tag, e.addr >> (INDEX_W + OFFSET_W));
                chk("op_index", op_index, (e.addr >> OFFSET_W) % (64'd1 << INDEX_W));
                chk("op_offset", op_offset, e.addr % (64'd1 << OFFSET_W));
                if (op_ready) begin
                    void'(exp_q.pop_front());
                    last = e;
                end
            end
        end else begin
            chk("hold_command", op_command, last.cmd);
            chk("hold_addr", {op_tag, op_index, op_offset}, last.addr);
        end
    end

    task automatic drive(input bit v, input logic [4:0] c, input logic [31:0] a, input bit r);
        @(posedge clk);
        #1;
        in_valid = v; in_command = c; in_address = a; op_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1; in_valid = 0; op_ready = 0;
        @(negedge clk);
        #1 rst = 0;
    endtask

    task automatic first_req();
        drive(1, 5'd0, 32'h1234_5678, 0);
        drive(0, 5'd0, 0, 0);
        @(negedge clk);
        chk("t1_valid", op_valid, 1);
        chk("t1_cmd", op_command, 0);
        chk("t1_tag", op_tag, 'h123);
        chk("t1_index", op_index, 'h1159);
        chk("t1_offset", op_offset, 'h38);
        chk("t1_rd", rd_cnt, 1);
        repeat (2) drive(0, 5'd0, 0, 1);
    endtask

    int l8[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int l9[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};

    initial begin
        #2;
        chk("rst_valid", op_valid, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_rd", rd_cnt, 0);
        repeat (2) @(negedge clk);
        #1 rst = 0;
        first_req();
        for (int i = 0; i < 9; i++) drive(1, 5'(l8[i % 8]), 32'h1000 + 32'(i * 64), 0);
        drive(0, 5'd0, 0, 0);
        @(negedge clk);
        chk("full_fill", fill_level, 8);
        chk("full_ready", in_ready, 0);
        repeat (12) drive(0, 5'd0, 0, 1);
        drive(1, 5'd7, 32'hAAAA_0000, 1);
        drive(1, 5'd12, 32'hBBBB_0000, 1);
        drive(1, 5'd1, 32'hCCCC_0040, 1);
        repeat (3) drive(0, 5'd0, 0, 1);
        @(negedge clk);
        chk("ill_err", err_cnt, 2);
        chk("ill_wr", wr_cnt, 1);
        for (int i = 0; i < 20; i++) drive(1, 5'(l9[i % 9]), $urandom, 1);
        repeat (3) drive(0, 5'd0, 0, 1);
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2) != 0);
        repeat (12) drive(0, 5'd0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 5'd3, $urandom, 0);
        drive(0, 5'd0, 0, 0);
        @(negedge clk);
        chk("pre_rst_fill", fill_level, 5);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_valid", op_valid, 0);
        chk("arst_fill", fill_level, 0);
        chk("arst_snp", snp_cnt, 0);
        chk("arst_rd", rd_cnt, 0);
        chk("arst_ready", in_ready, 0);
        @(negedge clk);
        #1 rst = 0;
        first_req();
        do_reset();
        for (int i = 0; i < 65534; i++) drive(1, 5'd0, $urandom, 1);
        drive(0, 5'd0, 0, 1);
        @(negedge clk);
        chk("sat_fffe", rd_cnt, 'hFFFE);
        for (int i = 0; i < 3; i++) drive(1, 5'd2, $urandom, 1);
        drive(0, 5'd0, 0, 1);
        @(negedge clk);
        chk("sat_ffff", rd_cnt, 'hFFFF);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) drive(0, 5'd0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
